prog_loader: RTL

//  Byte-stream program loader for MCPU: receives a framed program image on a valid/ready byte

---
 rtl/prog_loader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: receives a framed, checksummed image on a valid/ready byte
// interface, writes it into RAM from address 0 and holds the CPU in reset until it is good.
module prog_loader #(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_SIZE   = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t      state, state_d;
    logic [15:0] len_q;
    logic [15:0] count_q;
    logic [7:0]  xor_q;
    logic [7:0]  hi_q;
    logic        xfer;
    logic        restart;
    logic [15:0] len_rx;
    logic [15:0] count_inc;

    assign xfer      = in_valid & in_ready;
    assign restart   = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign len_rx    = {hi_q, in_data};
    assign count_inc = count_q + 16'd1;

    function automatic logic receiving(input state_t s);
        return s inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK};
    endfunction

    // NOTE: state_d is defaulted before the case so every path assigns it and no latch is inferred.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN_HI;
            S_LEN_HI:  if (xfer) state_d = S_LEN_LO;
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_rx == 16'd0)                  state_d = S_CHECK;
                    else if (len_rx > 16'(RAM_SIZE))      state_d = S_ERROR;
                    else                                  state_d = S_DATA_HI;
                end
            end
            S_DATA_HI: if (xfer) state_d = S_DATA_LO;
            S_DATA_LO: if (xfer) state_d = (count_inc == len_q) ? S_CHECK : S_DATA_HI;
            S_CHECK:   if (xfer) state_d = (in_data == xor_q) ? S_DONE : S_ERROR;
            default:   state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they change together with it.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            count_q   <= '0;
            xor_q     <= '0;
            hi_q      <= '0;
            len_q     <= '0;
        end else begin
            state     <= state_d;
            in_ready  <= receiving(state_d);
            busy      <= receiving(state_d);
            done      <= (state_d == S_DONE);
            error     <= (state_d == S_ERROR);
            cpu_reset <= (state_d != S_DONE);
            mem_we    <= 1'b0;

            if (restart) begin
                count_q <= '0;
                xor_q   <= '0;
            end

            if (xfer) begin
                case (state)
                    S_LEN_HI, S_DATA_HI: begin
                        hi_q  <= in_data;
                        xor_q <= xor_q ^ in_data;
                    end
                    S_LEN_LO: begin
                        len_q <= len_rx;
                        xor_q <= xor_q ^ in_data;
                    end
                    S_DATA_LO: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= count_q[ADDR_WIDTH-1:0];
                        mem_wdata <= WORD_SIZE'({hi_q, in_data});
                        count_q   <= count_inc;
                        xor_q     <= xor_q ^ in_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
